// File: rtl/mips8_shift_seq.sv
// rtl/mips8_shift_seq.sv - multi-cycle one-bit-per-clock shift engine feeding the shift result mux
// Trades the barrel shifter for a data register that steps once per cycle until the count runs out.
module mips8_shift_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic               in_arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SR   = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               arith_q, arith_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            arith_q <= arith_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        arith_d   = arith_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = in_shamt;
                    op_d    = in_op;
                    arith_d = in_arith;
                    // Zero-length work skips SHIFT so the result is ready one edge after accept.
                    if (in_op == OP_NONE || in_shamt == '0)
                        state_d = ST_HOLD;
                    else
                        state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                unique case (op_q)
                    OP_SLL:  data_d = {data_q[WIDTH-2:0], 1'b0};
                    OP_SR:   data_d = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    OP_ROTR: data_d = {data_q[0], data_q[WIDTH-1:1]};
                    default: data_d = data_q;
                endcase
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1))
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_data = data_q;
    assign out_sel  = op_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
